rp2a03_status_reg: RTL

RP2A03_STATUS_REG -- requirements
Module: RP2A03_STATUS_REG

---
 rtl/rp2a03_status_reg.sv | 140 ++++++++++++++
 1 files changed

// File: rtl/rp2a03_status_reg.sv
// RP2A03 processor status register (N,V,D,I,Z,C) with NMI edge detection
// and the registered interrupt-request handshake towards the decoder.
module rp2a03_status_reg #(
  parameter logic [7:0] P_RST = 8'h24
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] alu_out,
  input  logic       alu_carry,
  input  logic       alu_overflow,
  input  logic [7:0] db,
  input  logic       load_nz,
  input  logic       load_nz_db,
  input  logic       load_c,
  input  logic       load_v,
  input  logic       bit_op,
  input  logic       load_p_db,
  input  logic       set_c,
  input  logic       clr_c,
  input  logic       set_i,
  input  logic       clr_i,
  input  logic       set_d,
  input  logic       clr_d,
  input  logic       clr_v,
  input  logic       nmi_n,
  input  logic       irq_n,
  input  logic       poll,
  input  logic       int_ack,
  input  logic       push_brk,
  output logic [7:0] p,
  output logic [7:0] p_push,
  output logic       int_req,
  output logic       int_is_nmi
);

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_REQ  = 1'b1;

  logic       flag_n, flag_v, flag_d, flag_i, flag_z, flag_c;
  logic       n_nxt, v_nxt, d_nxt, i_nxt, z_nxt, c_nxt;
  logic       i_dly;
  logic       nmi_prev, nmi_pend, nmi_edge;
  logic [0:0] state;
  logic       take_int, ack_int;
  logic       alu_zero, db_zero;
  logic       unused_db;

  assign unused_db = ^db[5:4];
  assign alu_zero  = (alu_out == 8'h00);
  assign db_zero   = (db == 8'h00);

  always_comb begin
    n_nxt = flag_n;
    if (load_p_db)       n_nxt = db[7];
    else if (bit_op)     n_nxt = db[7];
    else if (load_nz_db) n_nxt = db[7];
    else if (load_nz)    n_nxt = alu_out[7];

    z_nxt = flag_z;
    if (load_p_db)       z_nxt = db[1];
    else if (bit_op)     z_nxt = alu_zero;
    else if (load_nz_db) z_nxt = db_zero;
    else if (load_nz)    z_nxt = alu_zero;

    v_nxt = flag_v;
    if (load_p_db)   v_nxt = db[6];
    else if (clr_v)  v_nxt = 1'b0;
    else if (bit_op) v_nxt = db[6];
    else if (load_v) v_nxt = alu_overflow;

    c_nxt = flag_c;
    if (load_p_db)   c_nxt = db[0];
    else if (set_c)  c_nxt = 1'b1;
    else if (clr_c)  c_nxt = 1'b0;
    else if (load_c) c_nxt = alu_carry;

    d_nxt = flag_d;
    if (load_p_db)  d_nxt = db[3];
    else if (set_d) d_nxt = 1'b1;
    else if (clr_d) d_nxt = 1'b0;

    // Entering the interrupt sequence always masks IRQ, whatever else is strobed.
    i_nxt = flag_i;
    if (int_ack)        i_nxt = 1'b1;
    else if (load_p_db) i_nxt = db[2];
    else if (set_i)     i_nxt = 1'b1;
    else if (clr_i)     i_nxt = 1'b0;
  end

  assign nmi_edge = nmi_prev & ~nmi_n;
  assign take_int = (state == ST_IDLE) & poll & (nmi_pend | (~irq_n & ~i_dly));
  assign ack_int  = (state == ST_REQ) & int_ack;

  always_ff @(posedge clk) begin
    if (rst) begin
      flag_n     <= P_RST[7];
      flag_v     <= P_RST[6];
      flag_d     <= P_RST[3];
      flag_i     <= P_RST[2];
      flag_z     <= P_RST[1];
      flag_c     <= P_RST[0];
      i_dly      <= P_RST[2];
      nmi_prev   <= 1'b0;
      nmi_pend   <= 1'b0;
      state      <= ST_IDLE;
      int_req    <= 1'b0;
      int_is_nmi <= 1'b0;
    end else begin
      flag_n   <= n_nxt;
      flag_v   <= v_nxt;
      flag_d   <= d_nxt;
      flag_i   <= i_nxt;
      flag_z   <= z_nxt;
      flag_c   <= c_nxt;
      i_dly    <= flag_i;
      nmi_prev <= nmi_n;
      // A fresh edge wins over the clear so a back-to-back NMI is not lost.
      nmi_pend <= nmi_edge | (nmi_pend & ~(ack_int & int_is_nmi));
      case (state)
        ST_IDLE: begin
          if (take_int) begin
            state      <= ST_REQ;
            int_req    <= 1'b1;
            int_is_nmi <= nmi_pend;
          end
        end
        default: begin
          if (ack_int) begin
            state   <= ST_IDLE;
            int_req <= 1'b0;
          end
        end
      endcase
    end
  end

  assign p      = {flag_n, flag_v, 1'b1, 1'b0, flag_d, flag_i, flag_z, flag_c};
  assign p_push = {flag_n, flag_v, 1'b1, push_brk, flag_d, flag_i, flag_z, flag_c};

endmodule
